// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle AVR issue/commit stage feeding an external combinational ALU
module alu_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int REG_COUNT   = 32,
    parameter int OPSEL_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_ready,
    output logic [OPSEL_COUNT-1:0] alu_opsel,
    output logic                   alu_enable,
    output logic [DATA_WIDTH-1:0]  alu_rd,
    output logic [DATA_WIDTH-1:0]  alu_rr,
    output logic [DATA_WIDTH-1:0]  alu_flags_in,
    input  logic [DATA_WIDTH-1:0]  alu_out,
    input  logic [DATA_WIDTH-1:0]  alu_flags_out,
    output logic [DATA_WIDTH-1:0]  sreg,
    output logic                   done,
    output logic                   illegal,
    input  logic [4:0]             dbg_addr,
    output logic [DATA_WIDTH-1:0]  dbg_data
);
    localparam logic [OPSEL_COUNT-1:0] OPSEL_NOP = 'd0;
    localparam logic [OPSEL_COUNT-1:0] OPSEL_ADD = 'd1;
    localparam logic [OPSEL_COUNT-1:0] OPSEL_ADC = 'd2;
    localparam logic [OPSEL_COUNT-1:0] OPSEL_SUB = 'd3;
    localparam logic [OPSEL_COUNT-1:0] OPSEL_AND = 'd4;
    localparam logic [OPSEL_COUNT-1:0] OPSEL_EOR = 'd5;
    localparam logic [OPSEL_COUNT-1:0] OPSEL_OR  = 'd6;
    localparam logic [OPSEL_COUNT-1:0] OPSEL_NEG = 'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t                   state, state_nxt;
    logic [INSTR_WIDTH-1:0]   ir;
    logic [DATA_WIDTH-1:0]    rf [REG_COUNT];
    logic [DATA_WIDTH-1:0]    res_q, flags_q;

    logic [4:0]               d_idx, r_idx;
    logic [DATA_WIDTH-1:0]    kval;
    logic                     is_ldi, is_neg, is_alu;
    logic [OPSEL_COUNT-1:0]   dec_op;

    // ir stays stable from capture until the next accept, so decode is purely combinational
    always_comb begin
        d_idx  = ir[8:4];
        r_idx  = {ir[9], ir[3:0]};
        kval   = {ir[11:8], ir[3:0]};
        is_ldi = 1'b0;
        is_neg = 1'b0;
        dec_op = OPSEL_NOP;
        if (ir[15:12] == 4'b1110) begin
            is_ldi = 1'b1;
            d_idx  = {1'b1, ir[7:4]};
        end else if (ir[15:9] == 7'b1001010 && ir[3:0] == 4'b0001) begin
            is_neg = 1'b1;
            dec_op = OPSEL_NEG;
        end else begin
            case (ir[15:10])
                6'b000011: dec_op = OPSEL_ADD;
                6'b000111: dec_op = OPSEL_ADC;
                6'b000110: dec_op = OPSEL_SUB;
                6'b001000: dec_op = OPSEL_AND;
                6'b001001: dec_op = OPSEL_EOR;
                6'b001010: dec_op = OPSEL_OR;
                default:   dec_op = OPSEL_NOP;
            endcase
        end
        is_alu = (dec_op != OPSEL_NOP);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (instr_valid) state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_ldi)      state_nxt = S_WB;
                else if (is_alu) state_nxt = S_EXEC;
                else             state_nxt = S_IDLE;
            end
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ir      <= '0;
            res_q   <= '0;
            flags_q <= '0;
            sreg    <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else begin
            state   <= state_nxt;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE:   if (instr_valid) ir <= instr;
                S_DECODE: if (!is_ldi && !is_alu) illegal <= 1'b1;
                S_EXEC: begin
                    res_q   <= alu_out;
                    flags_q <= alu_flags_out;
                end
                S_WB: begin
                    rf[d_idx] <= is_ldi ? kval : res_q;
                    if (!is_ldi) sreg <= flags_q;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NEG is unary: the ALU sees Rd with a zero second operand
    assign instr_ready  = (state == S_IDLE) && rst_n;
    assign alu_enable   = (state == S_EXEC);
    assign alu_opsel    = (state == S_IDLE) ? OPSEL_NOP : dec_op;
    assign alu_rd       = (state == S_EXEC) ? rf[d_idx] : '0;
    assign alu_rr       = (state == S_EXEC && !is_neg) ? rf[r_idx] : '0;
    assign alu_flags_in = sreg;
    assign dbg_data     = rf[dbg_addr];
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer with an AVR ALU model
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [3:0]  alu_opsel;
    logic        alu_enable;
    logic [7:0]  alu_rd, alu_rr, alu_flags_in, alu_out, alu_flags_out, sreg;
    logic        done, illegal;
    logic [4:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] g_rf [32];
    logic [7:0] g_sreg;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_opsel(alu_opsel), .alu_enable(alu_enable),
        .alu_rd(alu_rd), .alu_rr(alu_rr), .alu_flags_in(alu_flags_in),
        .alu_out(alu_out), .alu_flags_out(alu_flags_out), .sreg(sreg),
        .done(done), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // kinds: 0 illegal, 1 ADD, 2 ADC, 3 SUB, 4 AND, 5 EOR, 6 OR, 7 NEG, 8 LDI
    function automatic int kind_of(input logic [15:0] w);
        casez (w)
            16'b1110_????_????_????: return 8;
            16'b1001_010?_????_0001: return 7;
            16'b0000_11??_????_????: return 1;
            16'b0001_11??_????_????: return 2;
            16'b0001_10??_????_????: return 3;
            16'b0010_00??_????_????: return 4;
            16'b0010_01??_????_????: return 5;
            16'b0010_10??_????_????: return 6;
            default:                 return 0;
        endcase
    endfunction

    // AVR flag semantics from the instruction set: C0 Z1 N2 V3 S4 H5 T6 I7
    function automatic logic [15:0] alu_calc(input int kind, input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] f);
        logic [8:0] s;
        logic [4:0] hs;
        logic [7:0] r, nf;
        logic       cin;
        nf  = f;
        r   = '0;
        cin = (kind == 2) ? f[0] : 1'b0;
        case (kind)
            1, 2: begin
                s     = {1'b0, a} + {1'b0, b} + {8'b0, cin};
                hs    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
                r     = s[7:0];
                nf[0] = s[8];
                nf[5] = hs[4];
                nf[3] = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3: begin
                r     = a - b;
                nf[0] = (a < b);
                nf[5] = (a[3:0] < b[3:0]);
                nf[3] = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4: begin r = a & b; nf[3] = 1'b0; end
            5: begin r = a ^ b; nf[3] = 1'b0; end
            6: begin r = a | b; nf[3] = 1'b0; end
            7: begin
                r     = 8'd0 - a;
                nf[0] = (r != 8'd0);
                nf[5] = r[3] | a[3];
                nf[3] = (r == 8'h80);
            end
            default: r = '0;
        endcase
        nf[2] = r[7];
        nf[1] = (r == 8'd0);
        nf[4] = nf[2] ^ nf[3];
        return {nf, r};
    endfunction

    function automatic int opsel_kind(input logic [3:0] op);
        case (op)
            4'd1: return 1;
            4'd2: return 2;
            4'd3: return 3;
            4'd4: return 4;
            4'd5: return 5;
            4'd6: return 6;
            4'd7: return 7;
            default: return 0;
        endcase
    endfunction

    always_comb begin
        {alu_flags_out, alu_out} = alu_calc(opsel_kind(alu_opsel), alu_rd, alu_rr, alu_flags_in);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic gold_reset();
        for (int i = 0; i < 32; i++) g_rf[i] = '0;
        g_sreg = '0;
    endtask

    task automatic gold_apply(input logic [15:0] w);
        int k;
        logic [4:0] d, r;
        logic [7:0] b;
        logic [15:0] v;
        k = kind_of(w);
        if (k == 8) begin
            d = {1'b1, w[7:4]};
            g_rf[d] = {w[11:8], w[3:0]};
        end else if (k != 0) begin
            d = w[8:4];
            r = {w[9], w[3:0]};
            b = (k == 7) ? 8'd0 : g_rf[r];
            v = alu_calc(k, g_rf[d], b, g_sreg);
            g_rf[d] = v[7:0];
            g_sreg  = v[15:8];
        end
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check(tag, {24'b0, dbg_data}, {24'b0, g_rf[i]});
        end
        check({tag, "_sreg"}, {24'b0, sreg}, {24'b0, g_sreg});
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    // issues one word from IDLE and follows it for six edges after the accept edge
    task automatic run_instr(input logic [15:0] w);
        int k, waited, n_done, n_ill, lat_done, lat_ill;
        logic [4:0] d, r;
        k = kind_of(w);
        d = w[8:4];
        r = {w[9], w[3:0]};
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        waited = 0;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_accept", {31'b0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        n_done = 0; n_ill = 0; lat_done = 0; lat_ill = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                check("exec_enable", {31'b0, alu_enable}, {31'b0, (k >= 1 && k <= 7)});
                if (k >= 1 && k <= 7) begin
                    check("exec_opsel", {28'b0, alu_opsel}, k);
                    check("exec_rd", {24'b0, alu_rd}, {24'b0, g_rf[d]});
                    check("exec_rr", {24'b0, alu_rr}, (k == 7) ? 32'd0 : {24'b0, g_rf[r]});
                end
            end
            if (done) begin n_done++; if (lat_done == 0) lat_done = i; end
            if (illegal) begin n_ill++; if (lat_ill == 0) lat_ill = i; end
        end
        check("done_count", n_done, (k == 0) ? 32'd0 : 32'd1);
        check("illegal_count", n_ill, (k == 0) ? 32'd1 : 32'd0);
        if (k == 0)      check("illegal_latency", lat_ill, 32'd1);
        else if (k == 8) check("ldi_done_latency", lat_done, 32'd2);
        else             check("alu_done_latency", lat_done, 32'd3);
        gold_apply(w);
        check_rf("rf");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [5:0] alu_ops [6];
        logic [15:0] w;
        logic [4:0] d, r;
        logic [7:0] kk;
        alu_ops = '{6'b000011, 6'b000111, 6'b000110, 6'b001000, 6'b001001, 6'b001010};
        gold_reset();

        #1;
        check("rst_ready", {31'b0, instr_ready}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_sreg", {24'b0, sreg}, 32'd0);
        check("rst_alu_enable", {31'b0, alu_enable}, 32'd0);
        check("rst_alu_opsel", {28'b0, alu_opsel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", {31'b0, instr_ready}, 32'd1);

        // reset during EXEC of an ADD, with nonzero registers present
        run_instr(16'hE70F);
        run_instr(16'hE011);
        @(negedge clk);
        instr = 16'h0F01;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_in_exec", {31'b0, alu_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_ready", {31'b0, instr_ready}, 32'd0);
        check("mid_reset_enable", {31'b0, alu_enable}, 32'd0);
        gold_reset();
        check_rf("rf_after_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", {31'b0, instr_ready}, 32'd1);
        check("no_done_after_reset", {31'b0, done}, 32'd0);
        check_rf("rf_after_release");

        // LDI, LDI, ADD: 0x7F + 0x01 overflows into 0x80
        run_instr(16'hE70F);
        run_instr(16'hE011);
        run_instr(16'h0F01);
        read_reg(5'd16, v);
        check("add_r16", {24'b0, v}, 32'h80);
        check("add_v", {31'b0, sreg[3]}, 32'd1);
        check("add_n", {31'b0, sreg[2]}, 32'd1);
        check("add_z", {31'b0, sreg[1]}, 32'd0);
        check("add_c", {31'b0, sreg[0]}, 32'd0);

        run_instr(16'hFFFF);

        // carry set by 0xFF+0x01 must survive EOR R16,R16
        run_instr(16'hEF0F);
        run_instr(16'hE011);
        run_instr(16'h0F01);
        check("carry_set", {31'b0, sreg[0]}, 32'd1);
        run_instr(16'hE505);
        run_instr(16'h2700);
        read_reg(5'd16, v);
        check("eor_r16", {24'b0, v}, 32'h00);
        check("eor_z", {31'b0, sreg[1]}, 32'd1);
        check("eor_c_kept", {31'b0, sreg[0]}, 32'd1);

        run_instr(16'hE001);
        run_instr(16'h9511);
        read_reg(5'd17, v);
        check("neg_r17", {24'b0, v}, 32'hFF);

        // instr_valid held across three ADDs: accepts every fourth cycle
        @(negedge clk);
        w = 16'h0F01;
        instr = w;
        instr_valid = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 12) instr_valid = 1'b0;
            check("b2b_ready", {31'b0, instr_ready}, {31'b0, (c % 4 == 0)});
            check("b2b_done", {31'b0, done}, {31'b0, (c > 0 && c % 4 == 0)});
            if (c > 0 && c % 4 == 0) begin
                gold_apply(w);
                read_reg(5'd16, v);
                check("b2b_r16", {24'b0, v}, {24'b0, g_rf[16]});
                check("b2b_sreg", {24'b0, sreg}, {24'b0, g_sreg});
            end
            @(negedge clk);
        end

        for (int n = 0; n < 40; n++) begin
            d  = 5'($urandom);
            r  = 5'($urandom);
            kk = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: w = {4'hE, kk[7:4], d[3:0], kk[3:0]};
                3, 4, 5, 6, 7: w = {alu_ops[$urandom_range(0, 5)], r[4], d, r[3:0]};
                8: w = {7'b1001010, d, 4'b0001};
                default: w = 16'($urandom);
            endcase
            run_instr(w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
